// File: rtl/axis_s_vlw_packer.sv
// AXI-Stream slave front end: buffers TDATA beats in a FIFO, packs RATIO beats
// per VLW word and writes frames sequentially into the FFT sample memory.
module axis_s_vlw_packer #(
   parameter int unsigned TDATA_WDT  = 32,
   parameter int unsigned VLW_WDT    = 64,
   parameter int unsigned FIFO_SIZE  = 16,
   parameter int unsigned FRAME_LOG2 = 12,
   parameter int unsigned MEM_OFFSET = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [TDATA_WDT-1:0]  s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic                  mem_wr_en,
   input  logic                  mem_wr_rdy,
   output logic [FRAME_LOG2-1:0] mem_wr_addr,
   output logic [VLW_WDT-1:0]    mem_wr_data,
   output logic                  frame_done,
   output logic                  err_early_tlast,
   output logic                  err_no_tlast,
   input  logic                  err_clr
);

   localparam int unsigned RATIO         = VLW_WDT / TDATA_WDT;
   localparam int unsigned FIFO_ADDR_WDT = $clog2(FIFO_SIZE);
   localparam int unsigned FRAME_LEN     = 2 ** FRAME_LOG2;
   localparam int unsigned BEAT_WDT      = $clog2(FRAME_LEN * RATIO);
   localparam int unsigned SLOT_WDT      = (RATIO > 1) ? $clog2(RATIO) : 1;

   localparam logic [BEAT_WDT-1:0]      LAST_BEAT = BEAT_WDT'(FRAME_LEN * RATIO - 1);
   localparam logic [BEAT_WDT-1:0]      BEAT_ONE  = BEAT_WDT'(1);
   localparam logic [SLOT_WDT-1:0]      LAST_SLOT = SLOT_WDT'(RATIO - 1);
   localparam logic [SLOT_WDT-1:0]      SLOT_ONE  = SLOT_WDT'(1);
   localparam logic [FRAME_LOG2-1:0]    ADDR_BASE = FRAME_LOG2'(MEM_OFFSET);
   localparam logic [FRAME_LOG2-1:0]    ADDR_ONE  = FRAME_LOG2'(1);
   localparam logic [FIFO_ADDR_WDT:0]   PTR_ONE   = (FIFO_ADDR_WDT + 1)'(1);

   if ((VLW_WDT % TDATA_WDT) != 0 || VLW_WDT < TDATA_WDT) begin : g_ratio_check
      $error("VLW_WDT must be an integer multiple of TDATA_WDT");
   end
   if (FIFO_SIZE < 2 || (FIFO_SIZE & (FIFO_SIZE - 1)) != 0) begin : g_fifo_check
      $error("FIFO_SIZE must be a power of 2 and at least 2");
   end

   typedef enum logic {RECV, DRAIN} state_t;

   state_t                   state, state_nxt;
   logic [TDATA_WDT:0]       fifo_mem [FIFO_SIZE];
   logic [FIFO_ADDR_WDT:0]   wr_ptr, rd_ptr;
   logic                     full, empty, push, pop, xfer;
   logic [TDATA_WDT:0]       pop_entry;
   logic [TDATA_WDT-1:0]     pop_beat;
   logic                     pop_last;
   logic [BEAT_WDT-1:0]      beat_cnt;
   logic [SLOT_WDT-1:0]      slot;
   logic [VLW_WDT-1:0]       acc, packed_word;
   logic [FRAME_LOG2-1:0]    addr;
   logic                     last_word;
   logic                     final_beat, frame_abort, word_done, set_early, set_no;

   // Extra pointer MSB separates full from empty so every entry is usable.
   assign full  = (wr_ptr[FIFO_ADDR_WDT] != rd_ptr[FIFO_ADDR_WDT]) &&
                  (wr_ptr[FIFO_ADDR_WDT-1:0] == rd_ptr[FIFO_ADDR_WDT-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   assign s_axis_tready = !rst && !full;
   assign push          = s_axis_tvalid && s_axis_tready;
   assign xfer          = mem_wr_en && mem_wr_rdy;
   assign pop           = !empty && (state == DRAIN || !mem_wr_en || mem_wr_rdy);
   assign pop_entry     = fifo_mem[rd_ptr[FIFO_ADDR_WDT-1:0]];
   assign pop_beat      = pop_entry[TDATA_WDT-1:0];
   assign pop_last      = pop_entry[TDATA_WDT];
   assign final_beat    = (beat_cnt == LAST_BEAT);

   assign mem_wr_addr = addr;
   assign frame_done  = xfer && last_word;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[FIFO_ADDR_WDT-1:0]] <= {s_axis_tlast, s_axis_tdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_comb begin
      packed_word = acc;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (slot == SLOT_WDT'(k)) packed_word[k*TDATA_WDT +: TDATA_WDT] = pop_beat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= RECV;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      frame_abort = 1'b0;
      word_done   = 1'b0;
      set_early   = 1'b0;
      set_no      = 1'b0;
      if (pop) begin
         case (state)
            RECV: begin
               if (pop_last && !final_beat) begin
                  frame_abort = 1'b1;
                  set_early   = 1'b1;
               end else begin
                  word_done = (slot == LAST_SLOT);
                  if (final_beat && !pop_last) begin
                     set_no    = 1'b1;
                     state_nxt = DRAIN;
                  end
               end
            end
            DRAIN: if (pop_last) state_nxt = RECV;
            default: state_nxt = RECV;
         endcase
      end
   end

   // The abort's address reset is ordered after the transfer increment so it
   // wins when the frame's last pending word leaves in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt    <= '0;
         slot        <= '0;
         acc         <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= '0;
         addr        <= ADDR_BASE;
         last_word   <= 1'b0;
      end else begin
         if (xfer) begin
            mem_wr_en <= 1'b0;
            addr      <= addr + ADDR_ONE;
         end
         if (pop && state == RECV) begin
            if (frame_abort) begin
               beat_cnt <= '0;
               slot     <= '0;
               addr     <= ADDR_BASE;
            end else begin
               acc      <= packed_word;
               beat_cnt <= final_beat ? '0 : beat_cnt + BEAT_ONE;
               if (word_done) begin
                  mem_wr_en   <= 1'b1;
                  mem_wr_data <= packed_word;
                  last_word   <= final_beat;
                  slot        <= '0;
               end else begin
                  slot <= slot + SLOT_ONE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_early_tlast <= 1'b0;
         err_no_tlast    <= 1'b0;
      end else if (err_clr) begin
         err_early_tlast <= 1'b0;
         err_no_tlast    <= 1'b0;
      end else begin
         if (set_early) err_early_tlast <= 1'b1;
         if (set_no)    err_no_tlast    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_s_vlw_packer.sv
// Directed + randomized bench for axis_s_vlw_packer; expected writes come from
// a frame-level model fed by the beats accepted on the AXIS port.
module tb_axis_s_vlw_packer;

   localparam int unsigned TW  = 32;
   localparam int unsigned VW  = 64;
   localparam int unsigned FS  = 4;
   localparam int unsigned FL  = 2;
   localparam int unsigned OFF = 0;
   localparam int unsigned BEATS_PER_FRAME = (2 ** FL) * (VW / TW);

   logic          clk;
   logic          rst;
   logic [TW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic          mem_wr_en;
   logic          mem_wr_rdy;
   logic [FL-1:0] mem_wr_addr;
   logic [VW-1:0] mem_wr_data;
   logic          frame_done;
   logic          err_early_tlast;
   logic          err_no_tlast;
   logic          err_clr;

   axis_s_vlw_packer #(
      .TDATA_WDT (TW),
      .VLW_WDT   (VW),
      .FIFO_SIZE (FS),
      .FRAME_LOG2(FL),
      .MEM_OFFSET(OFF)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .s_axis_tlast   (s_axis_tlast),
      .mem_wr_en      (mem_wr_en),
      .mem_wr_rdy     (mem_wr_rdy),
      .mem_wr_addr    (mem_wr_addr),
      .mem_wr_data    (mem_wr_data),
      .frame_done     (frame_done),
      .err_early_tlast(err_early_tlast),
      .err_no_tlast   (err_no_tlast),
      .err_clr        (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {logic [FL-1:0] addr; logic [VW-1:0] data; logic done;} wr_t;
   typedef struct {logic [TW-1:0] d; logic l;} beat_t;

   wr_t           exp_q[$];
   beat_t         tx_q[$];
   logic [TW-1:0] cur[$];
   bit            drain, m_early, m_no;
   int            n_checks, n_errors, n_acc, n_done_seen, n_done_exp;
   bit            acc_flag, gap_en, hold_prev;
   int            rdy_mode;
   logic          rdy_fix;
   logic [VW-1:0] prev_data;
   logic [FL-1:0] prev_addr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Frame rules applied to the accepted beat stream, in arrival order.
   function automatic void model_accept(input logic [TW-1:0] d, input logic l);
      int n;
      wr_t w;
      if (drain) begin
         if (l) drain = 1'b0;
         return;
      end
      cur.push_back(d);
      n = cur.size();
      if (l && n < BEATS_PER_FRAME) begin
         m_early = 1'b1;
         cur.delete();
         return;
      end
      if (n % 2 == 0) begin
         w.addr = FL'((n / 2 - 1) + OFF);
         w.data = {cur[n-1], cur[n-2]};
         w.done = (n == BEATS_PER_FRAME);
         exp_q.push_back(w);
      end
      if (n == BEATS_PER_FRAME) begin
         if (!l) begin
            m_no  = 1'b1;
            drain = 1'b1;
         end
         cur.delete();
      end
   endfunction

   task automatic sample();
      wr_t e;
      if (rst) begin
         acc_flag  = 1'b0;
         hold_prev = 1'b0;
         cur.delete();
         exp_q.delete();
         drain   = 1'b0;
         m_early = 1'b0;
         m_no    = 1'b0;
         return;
      end
      if (err_clr) begin
         m_early = 1'b0;
         m_no    = 1'b0;
      end
      acc_flag = s_axis_tvalid && s_axis_tready;
      if (acc_flag) begin
         n_acc++;
         model_accept(s_axis_tdata, s_axis_tlast);
      end
      if (hold_prev) begin
         check("hold_en", 64'(mem_wr_en), 64'd1);
         check("hold_data", mem_wr_data, prev_data);
         check("hold_addr", 64'(mem_wr_addr), 64'(prev_addr));
      end
      if (mem_wr_en && mem_wr_rdy) begin
         if (exp_q.size() == 0) begin
            check("write_expected", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(mem_wr_addr), 64'(e.addr));
            check("wr_data", mem_wr_data, e.data);
            check("wr_frame_done", 64'(frame_done), 64'(e.done));
            if (e.done) n_done_exp++;
         end
      end else begin
         check("done_idle", 64'(frame_done), 64'd0);
      end
      if (frame_done) n_done_seen++;
      hold_prev = mem_wr_en && !mem_wr_rdy;
      prev_data = mem_wr_data;
      prev_addr = mem_wr_addr;
   endtask

   task automatic drive();
      bit hold;
      if (acc_flag && tx_q.size() > 0) void'(tx_q.pop_front());
      hold = s_axis_tvalid && !acc_flag && tx_q.size() > 0;
      if (tx_q.size() > 0 && (hold || !gap_en || $urandom_range(3) != 0)) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = tx_q[0].d;
         s_axis_tlast  = tx_q[0].l;
      end else begin
         s_axis_tvalid = 1'b0;
         s_axis_tdata  = $urandom;
         s_axis_tlast  = 1'($urandom_range(1));
      end
      case (rdy_mode)
         1:       mem_wr_rdy = !mem_wr_rdy;
         2:       mem_wr_rdy = 1'($urandom_range(1));
         default: mem_wr_rdy = rdy_fix;
      endcase
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic queue_frame(input int n, input int last_idx, input logic [TW-1:0] base, input bit rnd);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.d = rnd ? TW'($urandom) : base + TW'(i);
         b.l = (i == last_idx);
         tx_q.push_back(b);
      end
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      rdy_mode = 0;
      rdy_fix  = 1'b1;
      while ((tx_q.size() > 0 || exp_q.size() > 0 || mem_wr_en) && k < budget) begin
         tick();
         k++;
      end
      repeat (FS + 4) tick();
      check("idle_reached", 64'(tx_q.size() + exp_q.size()), 64'd0);
   endtask

   task automatic check_errors(input string tag);
      check({tag, "_err_early"}, 64'(err_early_tlast), 64'(m_early));
      check({tag, "_err_no"}, 64'(err_no_tlast), 64'(m_no));
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("clr_err_early", 64'(err_early_tlast), 64'd0);
      check("clr_err_no", 64'(err_no_tlast), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
      check({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
      check({tag, "_wr_addr"}, 64'(mem_wr_addr), 64'(OFF));
      check({tag, "_wr_data"}, mem_wr_data, 64'd0);
      check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
      check({tag, "_err_early"}, 64'(err_early_tlast), 64'd0);
      check({tag, "_err_no"}, 64'(err_no_tlast), 64'd0);
   endtask

   initial begin
      int n0, k;
      n_checks = 0; n_errors = 0; n_acc = 0; n_done_seen = 0; n_done_exp = 0;
      acc_flag = 0; gap_en = 0; hold_prev = 0; drain = 0; m_early = 0; m_no = 0;
      rdy_mode = 0; rdy_fix = 1'b0;
      rst = 1'b1; err_clr = 1'b0; mem_wr_rdy = 1'b0;
      s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;

      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      #1;
      check("tready_after_rst", 64'(s_axis_tready), 64'd1);

      // good frame, sequential data
      rdy_fix = 1'b1;
      queue_frame(8, 7, 32'h1, 1'b0);
      wait_idle(100);
      check_errors("good");

      // memory backpressure from an idle start: 2 beats packed + FIFO_SIZE buffered
      rdy_fix = 1'b0;
      n0 = n_acc;
      queue_frame(8, 7, 32'h11, 1'b0);
      repeat (20) tick();
      check("bp_accepted", 64'(n_acc - n0), 64'(2 + FS));
      check("bp_tready", 64'(s_axis_tready), 64'd0);
      wait_idle(100);
      check_errors("bp");

      // early TLAST then a good frame
      queue_frame(5, 4, 32'h21, 1'b0);
      queue_frame(8, 7, 32'h31, 1'b0);
      wait_idle(100);
      check_errors("early");
      clear_errors();

      // missing TLAST, 3 drained beats, then a good frame
      queue_frame(8, -1, 32'h41, 1'b0);
      queue_frame(3, 2, 32'h51, 1'b0);
      queue_frame(8, 7, 32'h61, 1'b0);
      wait_idle(100);
      check_errors("notlast");
      clear_errors();

      // reset mid-frame after beat 3
      n0 = n_acc;
      queue_frame(8, 7, 32'h71, 1'b0);
      k = 0;
      while (n_acc - n0 < 3 && k < 50) begin
         tick();
         k++;
      end
      check("rst_mid_beats", 64'(n_acc - n0), 64'd3);
      rst = 1'b1;
      rdy_fix = 1'b0;
      tx_q.delete();
      s_axis_tvalid = 1'b0;
      tick();
      tick();
      check_reset_outputs("midrst");
      rst = 1'b0;
      queue_frame(8, 7, 32'h81, 1'b0);
      wait_idle(100);
      check_errors("after_rst");

      // FIFO boundary: continuous valid, ready toggling every cycle
      rdy_mode = 1;
      for (int f = 0; f < 3; f++) queue_frame(8, 7, 32'h0, 1'b1);
      k = 0;
      while (tx_q.size() > 0 && k < 300) begin
         tick();
         k++;
      end
      wait_idle(200);
      check_errors("toggle");

      // randomized gaps and ready, mixing good and early-TLAST frames
      rdy_mode = 2;
      gap_en   = 1'b1;
      for (int f = 0; f < 6; f++) begin
         if (f == 3) queue_frame(3, 2, 32'h0, 1'b1);
         else        queue_frame(8, 7, 32'h0, 1'b1);
      end
      k = 0;
      while (tx_q.size() > 0 && k < 1000) begin
         tick();
         k++;
      end
      gap_en = 1'b0;
      wait_idle(300);
      check_errors("random");

      check("frame_done_count", 64'(n_done_seen), 64'(n_done_exp));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
